// File: rtl/sn76489_pkg.sv
// sn76489_pkg: shared constants and types for the SN76489 noise channel.
//   - noiseFeed encodings (noise_feed_e)
//   - rate counter reload values 16/32/64
//   - LFSR width, seed and white-noise tap for both the 15-bit and 16-bit
//     variants. The active variant is chosen by the SN76489_NOISE_15BIT_EN macro.
//     When the macro is undefined, the 16-bit variant is used.
package sn76489_pkg;

  typedef enum logic [1:0] {
    FEED_16    = 2'b00,
    FEED_32    = 2'b01,
    FEED_64    = 2'b10,
    FEED_TONE3 = 2'b11
  } noise_feed_e;

  localparam int         RATE_W    = 10;
  localparam logic [9:0] RELOAD_16 = 10'd16;
  localparam logic [9:0] RELOAD_32 = 10'd32;
  localparam logic [9:0] RELOAD_64 = 10'd64;

  localparam int          LFSR15_W    = 15;
  localparam logic [14:0] LFSR15_SEED = 15'h4000;
  localparam int          LFSR15_TAP  = 1;

  localparam int          LFSR16_W    = 16;
  localparam logic [15:0] LFSR16_SEED = 16'h8000;
  localparam int          LFSR16_TAP  = 3;

`ifdef SN76489_NOISE_15BIT_EN
  localparam int                LFSR_W    = LFSR15_W;
  localparam int                LFSR_TAP  = LFSR15_TAP;
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR15_SEED;
`else
  localparam int                LFSR_W    = LFSR16_W;
  localparam int                LFSR_TAP  = LFSR16_TAP;
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR16_SEED;
`endif

  // Reload value for the rate counter. The tone-3 mode never uses the counter,
  // so it reloads to the shortest period.
  function automatic logic [RATE_W-1:0] reload_for(input noise_feed_e feed);
    logic [RATE_W-1:0] r;
    case (feed)
      FEED_16: r = RELOAD_16;
      FEED_32: r = RELOAD_32;
      FEED_64: r = RELOAD_64;
      default: r = RELOAD_16;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sn76489_noise_generator_lfsr.sv
// sn76489_lfsr: noise shift register with seed, feedback select and shift enable.
//   clock   : system clock
//   reset   : asynchronous active-high reset; loads the seed
//   reseed  : synchronous reload of the seed; this has priority over shift
//   shift   : shift right by one bit this cycle
//   white   : 1 = XOR feedback (white noise), 0 = rotate (periodic noise)
//   lfsr    : current register contents
// The width, the seed and the tap come from sn76489_pkg. They follow the
// SN76489_NOISE_15BIT_EN macro.
module sn76489_lfsr
  import sn76489_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              reseed,
  input  logic              shift,
  input  logic              white,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_r;
  logic              feedback_s;

  // Select the bit that enters at the MSB.
  always_comb begin
    if (white) begin
      feedback_s = lfsr_r[0] ^ lfsr_r[LFSR_TAP];
    end else begin
      feedback_s = lfsr_r[0];
    end
  end

  // Shift register. A reseed wins over a shift in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_r <= LFSR_SEED;
    end else if (shift) begin
      lfsr_r <= {feedback_s, lfsr_r[LFSR_W-1:1]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: rtl/sn76489_noise_generator.sv
// sn76489_noise_generator: SN76489 noise channel with a prescaler, a rate
// counter, a noise flip-flop, an LFSR and an attenuated output level.
//   clock         : system clock
//   reset         : asynchronous active-high reset
//   noiseFeed     : shift rate: 00/01/10 = 16/32/64 ticks, 11 = tone3Edge
//   noiseFeedback : 1 = white noise, 0 = periodic noise
//   attNoise      : attenuation. 0x0 is the loudest setting and 0xF is silent.
//   noiseWrite    : pulse on a write to the noise control register
//   tone3Edge     : pulse on each toggle of the tone-3 output
//   noiseOut      : registered linear output level
// Parameter PRESCALE sets the number of clocks per internal tick.
// The SN76489_NOISE_15BIT_EN macro selects the 15-bit LFSR. Without the macro,
// the LFSR is 16 bits.
module sn76489_noise_generator
  import sn76489_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] noiseFeed,
  input  logic       noiseFeedback,
  input  logic [3:0] attNoise,
  input  logic       noiseWrite,
  input  logic       tone3Edge,
  output logic [3:0] noiseOut
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  prescale_r;
  logic              tick_s;
  logic [RATE_W-1:0] rate_r;
  logic [RATE_W-1:0] rate_next_s;
  logic              noise_ff_r;
  logic              noise_ff_next_s;
  logic              toggle_s;
  logic              shift_s;
  logic [LFSR_W-1:0] lfsr_s;
  logic [3:0]        level_s;
  logic [3:0]        noise_out_r;
  noise_feed_e       feed_s;

  // Decode the feed selection and the tick strobe.
  always_comb begin
    feed_s = noise_feed_e'(noiseFeed);
    tick_s = (prescale_r == PRE_LAST);
  end

  // Free-running modulo-PRESCALE prescaler. A register write does not disturb it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_r <= '0;
    end else if (tick_s) begin
      prescale_r <= '0;
    end else begin
      prescale_r <= prescale_r + PRE_W'(1);
    end
  end

  // Rate counter and flip-flop toggle source. A register write suppresses any
  // toggle in the same cycle. A feed change without a write is only picked up
  // at the next reload.
  always_comb begin
    rate_next_s = rate_r;
    toggle_s    = 1'b0;
    if (noiseWrite) begin
      rate_next_s = reload_for(feed_s);
    end else if (feed_s == FEED_TONE3) begin
      toggle_s = tone3Edge;
    end else if (tick_s) begin
      if (rate_r == 10'd1) begin
        rate_next_s = reload_for(feed_s);
        toggle_s    = 1'b1;
      end else begin
        rate_next_s = rate_r - 10'd1;
      end
    end else begin
      rate_next_s = rate_r;
    end
  end

  // Next flip-flop state. The LFSR steps only on the 0->1 edge of the flip-flop.
  always_comb begin
    if (noiseWrite) begin
      noise_ff_next_s = 1'b0;
    end else if (toggle_s) begin
      noise_ff_next_s = ~noise_ff_r;
    end else begin
      noise_ff_next_s = noise_ff_r;
    end
    shift_s = toggle_s & ~noise_ff_r;
    if (lfsr_s[0]) begin
      level_s = 4'hF - attNoise;
    end else begin
      level_s = 4'h0;
    end
  end

  // Rate counter, noise flip-flop and output level registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rate_r      <= RELOAD_16;
      noise_ff_r  <= 1'b0;
      noise_out_r <= 4'h0;
    end else begin
      rate_r      <= rate_next_s;
      noise_ff_r  <= noise_ff_next_s;
      noise_out_r <= level_s;
    end
  end

  sn76489_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .reseed (noiseWrite),
    .shift  (shift_s),
    .white  (noiseFeedback),
    .lfsr   (lfsr_s)
  );

  assign noiseOut = noise_out_r;

endmodule
